// File: rtl/fft_r2_iter.sv
// fft_r2_iter: sequential radix-2 decimation-in-time FFT/IFFT engine.
//
// Samples are written in bit-reversed order into an in-place complex register
// array, then log2(N_PTS) stages of N_PTS/2 butterflies run at one butterfly
// per clock. Finally the bins are streamed out in natural order. Every
// butterfly halves its results, so the total scaling is 1/N_PTS in both
// directions.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input sample handshake (in_ready high only in LOAD)
//   in_re, in_im        time-domain sample, natural order
//   in_inv              0 = FFT, 1 = IFFT, taken with the first sample of a frame
//   out_valid/out_ready output bin handshake (out_valid high only in UNLOAD)
//   out_re, out_im      frequency-domain bin
//   out_idx             index of the bin currently presented
//   out_last            high together with bin N_PTS-1
//   dbg_state           current FSM state (LOAD=0, COMPUTE=1, UNLOAD=2)
//
// Handshake rule for both ports: a transfer happens on a rising clock edge
// where valid and ready are both high. The sender keeps valid and its payload
// stable until that edge. The receiver may change ready freely. Valid never
// depends on ready.
module fft_r2_iter #(
  parameter int N_PTS  = 8,
  parameter int DATA_W = 16,
  parameter int TW_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_re,
  input  logic [DATA_W-1:0]          in_im,
  input  logic                       in_inv,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_re,
  output logic [DATA_W-1:0]          out_im,
  output logic [$clog2(N_PTS)-1:0]   out_idx,
  output logic                       out_last,
  output logic [1:0]                 dbg_state
);

  localparam int LOG_N = $clog2(N_PTS);
  // Product width: DATA_W x (TW_W+1) after twiddle negation, plus one bit
  // for the sum of two products.
  localparam int PW    = DATA_W + TW_W + 2;
  localparam real PI   = 3.14159265358979323846;

  localparam logic [LOG_N-1:0] ONE      = LOG_N'(1);
  localparam logic [LOG_N-1:0] LAST_IDX = LOG_N'(N_PTS - 1);
  localparam logic [LOG_N-1:0] LAST_S   = LOG_N'(LOG_N - 1);

  localparam logic signed [DATA_W+1:0] HALF_HI = {3'b000, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W+1:0] HALF_LO = {3'b111, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] D_MAX   = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] D_MIN   = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_UNLOAD  = 2'd2
  } state_t;

  // Quantise a real in [-1, 1] to Q1.(TW_W-1), rounding to nearest.
  // +1.0 is not representable and saturates.
  function automatic logic signed [TW_W-1:0] tw_quant(input real x);
    real scaled;
    int  v;
    int  v_max;
    v_max  = (1 << (TW_W - 1)) - 1;
    scaled = x * (2.0 ** (TW_W - 1));
    v      = $rtoi($floor(scaled + 0.5));
    if (v > v_max) v = v_max;
    if (v < -v_max - 1) v = -v_max - 1;
    return TW_W'(v);
  endfunction

  function automatic logic [LOG_N-1:0] bit_rev(input logic [LOG_N-1:0] v);
    logic [LOG_N-1:0] r;
    for (int i = 0; i < LOG_N; i++) r[i] = v[LOG_N-1-i];
    return r;
  endfunction

  // Floor-halve a DATA_W+2 bit sum. For |W| <= 1 this always fits; the clamp
  // only guards against pathological inputs near full scale on both parts.
  function automatic logic signed [DATA_W-1:0] half_sat(input logic signed [DATA_W+1:0] v);
    logic signed [DATA_W+1:0] h;
    h = v >>> 1;
    if (h > HALF_HI) return D_MAX;
    if (h < HALF_LO) return D_MIN;
    return DATA_W'(h);
  endfunction

  // Twiddle ROM: W^i = cos(2*pi*i/N) - j*sin(2*pi*i/N), i = 0..N/2-1.
  logic signed [TW_W-1:0] rom_re [N_PTS/2];
  logic signed [TW_W-1:0] rom_im [N_PTS/2];

  for (genvar gi = 0; gi < N_PTS / 2; gi++) begin : g_rom
    localparam real ANG = 2.0 * PI * gi / N_PTS;
    assign rom_re[gi] = tw_quant($cos(ANG));
    assign rom_im[gi] = tw_quant(-$sin(ANG));
  end

  // State and counters.
  state_t           state_q, state_d;
  logic [LOG_N-1:0] load_cnt_q, load_cnt_d;
  logic [LOG_N-1:0] stage_q, stage_d;
  logic [LOG_N-1:0] grp_q, grp_d;
  logic [LOG_N-1:0] k_q, k_d;
  logic [LOG_N-1:0] out_idx_q, out_idx_d;
  logic             inv_q, inv_d;

  // In-place sample array; its contents need no reset.
  logic signed [DATA_W-1:0] mem_re_q [N_PTS];
  logic signed [DATA_W-1:0] mem_im_q [N_PTS];

  logic                     load_we;
  logic                     bf_we;
  logic [LOG_N-1:0]         ld_addr;
  logic [LOG_N-1:0]         half_span;
  logic [LOG_N-1:0]         num_grp;
  logic [LOG_N-1:0]         a_idx;
  logic [LOG_N-1:0]         b_idx;
  logic [LOG_N-2:0]         tw_idx;
  logic signed [DATA_W-1:0] a_re, a_im, b_re, b_im;
  logic signed [TW_W-1:0]   w_re, w_im;
  logic signed [PW-1:0]     br_x, bi_x, wr_x, wi_x;
  logic signed [PW-1:0]     p_re, p_im;
  logic signed [DATA_W:0]   t_re, t_im;
  logic signed [DATA_W-1:0] na_re, na_im, nb_re, nb_im;

  // Butterfly addressing and arithmetic.
  always_comb begin
    ld_addr   = bit_rev(load_cnt_q);
    half_span = ONE << stage_q;
    num_grp   = ONE << (LAST_S - stage_q);
    a_idx     = (grp_q << (stage_q + ONE)) + k_q;
    b_idx     = a_idx + half_span;
    // Twiddle exponent k * N / 2^(s+1) = k << (S-1-s).
    tw_idx    = (LOG_N-1)'(k_q << (LAST_S - stage_q));

    a_re = mem_re_q[a_idx];
    a_im = mem_im_q[a_idx];
    b_re = mem_re_q[b_idx];
    b_im = mem_im_q[b_idx];
    w_re = rom_re[tw_idx];
    w_im = rom_im[tw_idx];

    // Conjugating by negating the imaginary part at full width keeps the
    // inverse twiddle exact, including -1.0 -> +1.0.
    br_x = PW'(b_re);
    bi_x = PW'(b_im);
    wr_x = PW'(w_re);
    wi_x = inv_q ? -PW'(w_im) : PW'(w_im);
    p_re = br_x * wr_x - bi_x * wi_x;
    p_im = br_x * wi_x + bi_x * wr_x;

    if (tw_idx == '0) begin
      // W^0 = 1 exactly; the quantised cosine would lose an LSB.
      t_re = (DATA_W+1)'(b_re);
      t_im = (DATA_W+1)'(b_im);
    end else begin
      t_re = (DATA_W+1)'(p_re >>> (TW_W - 1));
      t_im = (DATA_W+1)'(p_im >>> (TW_W - 1));
    end

    na_re = half_sat((DATA_W+2)'(a_re) + (DATA_W+2)'(t_re));
    na_im = half_sat((DATA_W+2)'(a_im) + (DATA_W+2)'(t_im));
    nb_re = half_sat((DATA_W+2)'(a_re) - (DATA_W+2)'(t_re));
    nb_im = half_sat((DATA_W+2)'(a_im) - (DATA_W+2)'(t_im));
  end

  // Next-state and handshake logic.
  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    stage_d    = stage_q;
    grp_d      = grp_q;
    k_d        = k_q;
    out_idx_d  = out_idx_q;
    inv_d      = inv_q;
    load_we    = 1'b0;
    bf_we      = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;

    case (state_q)
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load_we = 1'b1;
          if (load_cnt_q == '0) inv_d = in_inv;
          if (load_cnt_q == LAST_IDX) begin
            load_cnt_d = '0;
            stage_d    = '0;
            grp_d      = '0;
            k_d        = '0;
            state_d    = ST_COMPUTE;
          end else begin
            load_cnt_d = load_cnt_q + ONE;
          end
        end
      end

      ST_COMPUTE: begin
        bf_we = 1'b1;
        // Nested counters: offset k inside a group, group g inside a stage.
        if (k_q + ONE != half_span) begin
          k_d = k_q + ONE;
        end else begin
          k_d = '0;
          if (grp_q + ONE != num_grp) begin
            grp_d = grp_q + ONE;
          end else begin
            grp_d = '0;
            if (stage_q == LAST_S) begin
              stage_d = '0;
              state_d = ST_UNLOAD;
            end else begin
              stage_d = stage_q + ONE;
            end
          end
        end
      end

      ST_UNLOAD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (out_idx_q == LAST_IDX) begin
            out_idx_d = '0;
            state_d   = ST_LOAD;
          end else begin
            out_idx_d = out_idx_q + ONE;
          end
        end
      end

      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_LOAD;
      load_cnt_q <= '0;
      stage_q    <= '0;
      grp_q      <= '0;
      k_q        <= '0;
      out_idx_q  <= '0;
      inv_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      stage_q    <= stage_d;
      grp_q      <= grp_d;
      k_q        <= k_d;
      out_idx_q  <= out_idx_d;
      inv_q      <= inv_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load_we) begin
      mem_re_q[ld_addr] <= in_re;
      mem_im_q[ld_addr] <= in_im;
    end
    if (bf_we) begin
      mem_re_q[a_idx] <= na_re;
      mem_im_q[a_idx] <= na_im;
      mem_re_q[b_idx] <= nb_re;
      mem_im_q[b_idx] <= nb_im;
    end
  end

  // Outputs are forced to zero outside UNLOAD so reset values hold at once.
  assign out_re    = (state_q == ST_UNLOAD) ? mem_re_q[out_idx_q] : '0;
  assign out_im    = (state_q == ST_UNLOAD) ? mem_im_q[out_idx_q] : '0;
  assign out_idx   = out_idx_q;
  assign out_last  = (state_q == ST_UNLOAD) && (out_idx_q == LAST_IDX);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fft_r2_iter.sv
// Self-checking bench for fft_r2_iter (N_PTS=8, 16-bit data and twiddles).
// A plain-arithmetic reference FFT inside the bench fills an expected queue;
// one compare process checks every output handshake, stall stability,
// first-output latency and in_ready behaviour around unload.
module tb_fft_r2_iter;

  localparam int N_PTS  = 8;
  localparam int DATA_W = 16;
  localparam int TW_W   = 16;
  localparam int LOG_N  = 3;
  localparam int LAT    = LOG_N * N_PTS / 2 + 1;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_re = '0;
  logic [DATA_W-1:0] in_im = '0;
  logic              in_inv = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] out_re;
  logic [DATA_W-1:0] out_im;
  logic [LOG_N-1:0]  out_idx;
  logic              out_last;
  logic [1:0]        dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  fft_r2_iter #(.N_PTS(N_PTS), .DATA_W(DATA_W), .TW_W(TW_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .in_inv(in_inv),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im),
    .out_idx(out_idx), .out_last(out_last),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [2*DATA_W-1:0] exp_q[$];
  int exp_idx = 0;
  int last_in_cyc = 0;
  bit lat_pending = 1'b0;
  bit stall_prev = 1'b0;
  bit last_hs_prev = 1'b0;
  bit bp_mode = 1'b0;
  logic [DATA_W-1:0] prev_re, prev_im;
  logic [LOG_N-1:0]  prev_idx;
  logic              prev_last;

  int tw_re[N_PTS/2];
  int tw_im[N_PTS/2];
  int x_re[N_PTS];
  int x_im[N_PTS];
  int y_re[N_PTS];
  int y_im[N_PTS];

  task automatic check(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fatal_timeout(input string name);
    check(1'b0, name, 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "bench stopped: %s", name);
  endtask

  function automatic int sx(input logic [DATA_W-1:0] v);
    return int'($signed(v));
  endfunction

  // ---------------- reference model ----------------
  function automatic int brev(input int v);
    int r;
    r = 0;
    for (int b = 0; b < LOG_N; b++) r = (r << 1) | ((v >> b) & 1);
    return r;
  endfunction

  function automatic int quant(input real x);
    int v;
    v = $rtoi($floor(x * (2.0 ** (TW_W - 1)) + 0.5));
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v;
  endfunction

  function automatic longint clamp16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Textbook in-place radix-2 DIT with the engine's per-stage halving.
  task automatic model_fft(input bit inv);
    longint ar[N_PTS];
    longint ai[N_PTS];
    for (int i = 0; i < N_PTS; i++) begin
      ar[brev(i)] = x_re[i];
      ai[brev(i)] = x_im[i];
    end
    for (int s = 0; s < LOG_N; s++) begin
      for (int base = 0; base < N_PTS; base += (2 << s)) begin
        for (int k = 0; k < (1 << s); k++) begin
          int ti, ia, ib;
          longint wr, wi, tr, tim, xa, ya;
          ia = base + k;
          ib = ia + (1 << s);
          ti = k * N_PTS / (2 << s);
          wr = tw_re[ti];
          wi = inv ? -tw_im[ti] : tw_im[ti];
          if (ti == 0) begin
            tr  = ar[ib];
            tim = ai[ib];
          end else begin
            tr  = (ar[ib] * wr - ai[ib] * wi) >>> (TW_W - 1);
            tim = (ar[ib] * wi + ai[ib] * wr) >>> (TW_W - 1);
          end
          xa = ar[ia];
          ya = ai[ia];
          ar[ia] = clamp16((xa + tr) >>> 1);
          ai[ia] = clamp16((ya + tim) >>> 1);
          ar[ib] = clamp16((xa - tr) >>> 1);
          ai[ib] = clamp16((ya - tim) >>> 1);
        end
      end
    end
    for (int i = 0; i < N_PTS; i++) begin
      y_re[i] = int'(ar[i]);
      y_im[i] = int'(ai[i]);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [2*DATA_W-1:0] exp_v;
    if (rst_n) begin
      if (in_valid && in_ready) last_in_cyc = cyc;
      if (last_hs_prev)
        check(in_ready === 1'b1 && out_valid === 1'b0, "in_ready_after_last", in_ready, 1);
      if (stall_prev)
        check(out_valid === 1'b1 && out_re === prev_re && out_im === prev_im &&
              out_idx === prev_idx && out_last === prev_last,
              "stall_stable", sx(out_re), sx(prev_re));
      last_hs_prev = 1'b0;
      stall_prev   = 1'b0;
      if (out_valid === 1'b1) begin
        check(in_ready === 1'b0, "in_ready_low_in_unload", in_ready, 0);
        if (lat_pending) begin
          check(cyc - last_in_cyc == LAT, "first_out_latency", cyc - last_in_cyc, LAT);
          lat_pending = 1'b0;
        end
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_bin", out_idx, -1);
          end else begin
            exp_v = exp_q.pop_front();
            check(out_re === exp_v[2*DATA_W-1:DATA_W], "bin_re",
                  sx(out_re), sx(exp_v[2*DATA_W-1:DATA_W]));
            check(out_im === exp_v[DATA_W-1:0], "bin_im",
                  sx(out_im), sx(exp_v[DATA_W-1:0]));
            check(int'(out_idx) == exp_idx, "bin_idx", out_idx, exp_idx);
            check(out_last === (exp_idx == N_PTS - 1), "bin_last", out_last, exp_idx == N_PTS - 1);
            if (out_last) last_hs_prev = 1'b1;
            exp_idx = (exp_idx + 1) % N_PTS;
          end
        end else begin
          stall_prev = 1'b1;
          prev_re    = out_re;
          prev_im    = out_im;
          prev_idx   = out_idx;
          prev_last  = out_last;
        end
      end
    end else begin
      stall_prev   = 1'b0;
      last_hs_prev = 1'b0;
      exp_idx      = 0;
    end
  end

  // ---------------- drivers ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Drives x_re/x_im as one frame. in_inv carries the mode only on the first
  // sample and random values afterwards; junk keeps in_valid asserted with
  // random data while the engine computes.
  task automatic drive_frame(input bit inv, input bit expect_out, input bit junk);
    bit got;
    int n;
    for (int i = 0; i < N_PTS; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_re    = DATA_W'(x_re[i]);
      in_im    = DATA_W'(x_im[i]);
      in_inv   = (i == 0) ? inv : 1'($urandom_range(0, 1));
      got = 1'b0;
      n = 0;
      while (!got) begin
        @(negedge clk);
        got = in_ready;
        @(posedge clk);
        #1;
        n++;
        if (!got && n > 200) fatal_timeout("in_ready_timeout");
      end
    end
    if (expect_out) lat_pending = 1'b1;
    if (junk) begin
      for (int j = 0; j < 10; j++) begin
        in_valid = 1'b1;
        in_re    = DATA_W'($urandom);
        in_im    = DATA_W'($urandom);
        in_inv   = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0) begin
      @(posedge clk);
      #1;
      n++;
      if (n > 500) fatal_timeout("drain_timeout");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input bit inv, input bit junk);
    model_fft(inv);
    for (int k = 0; k < N_PTS; k++)
      exp_q.push_back({DATA_W'(y_re[k]), DATA_W'(y_im[k])});
    drive_frame(inv, 1'b1, junk);
    wait_drain();
  endtask

  task automatic set_const(input int re, input int im);
    for (int i = 0; i < N_PTS; i++) begin
      x_re[i] = re;
      x_im[i] = im;
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check(out_valid === 1'b0 && out_re === '0 && out_im === '0 &&
          out_idx === '0 && out_last === 1'b0, name, out_valid, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit ok;
    for (int i = 0; i < N_PTS / 2; i++) begin
      tw_re[i] = quant($cos(2.0 * 3.14159265358979323846 * i / N_PTS));
      tw_im[i] = quant(-$sin(2.0 * 3.14159265358979323846 * i / N_PTS));
    end

    #12;
    check_reset_outputs("reset_outputs");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check(in_ready === 1'b1, "in_ready_after_reset", in_ready, 1);
    @(posedge clk);
    #1;

    // Impulse.
    set_const(0, 0);
    x_re[0] = 16384;
    model_fft(1'b0);
    ok = 1'b1;
    for (int k = 0; k < N_PTS; k++) if (y_re[k] != 2048 || y_im[k] != 0) ok = 1'b0;
    check(ok, "model_impulse", y_re[5], 2048);
    run_frame(1'b0, 1'b0);

    // DC.
    set_const(16384, 0);
    model_fft(1'b0);
    ok = (y_re[0] == 16384) && (y_im[0] == 0);
    for (int k = 1; k < N_PTS; k++) if (y_re[k] != 0 || y_im[k] != 0) ok = 1'b0;
    check(ok, "model_dc", y_re[0], 16384);
    run_frame(1'b0, 1'b0);

    // Full-scale negative.
    set_const(-32768, 0);
    model_fft(1'b0);
    ok = (y_re[0] == -32768) && (y_im[0] == 0);
    for (int k = 1; k < N_PTS; k++) if (y_re[k] != 0 || y_im[k] != 0) ok = 1'b0;
    check(ok, "model_fullscale_neg", y_re[0], -32768);
    run_frame(1'b0, 1'b0);

    // Shifted impulse, inverse then forward.
    set_const(0, 0);
    x_re[1] = 16384;
    model_fft(1'b1);
    check(y_re[2] >= -1 && y_re[2] <= 1 && y_im[2] >= 2047 && y_im[2] <= 2049,
          "model_inv_bin2", y_im[2], 2048);
    run_frame(1'b1, 1'b0);
    model_fft(1'b0);
    check(y_re[2] >= -1 && y_re[2] <= 1 && y_im[2] >= -2049 && y_im[2] <= -2047,
          "model_fwd_bin2", y_im[2], -2048);
    run_frame(1'b0, 1'b0);

    // Random frames with random backpressure; one keeps in_valid busy
    // during compute.
    bp_mode = 1'b1;
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < N_PTS; i++) begin
        x_re[i] = int'($urandom_range(0, 32766)) - 16383;
        x_im[i] = int'($urandom_range(0, 32766)) - 16383;
      end
      run_frame(1'($urandom_range(0, 1)), f == 2);
    end
    bp_mode = 1'b0;

    // Reset in the fifth compute cycle of a frame, then a fresh DC frame.
    set_const(1000, -2000);
    drive_frame(1'b0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid_compute_outputs");
    check(in_ready === 1'b1, "reset_mid_compute_in_ready", in_ready, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check(in_ready === 1'b1, "in_ready_after_mid_reset", in_ready, 1);
    @(posedge clk);
    #1;
    set_const(16384, 0);
    run_frame(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
